// File: rtl/stream_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_cmd_decoder_pkg
//  Description : Opcodes, state encoding and command-field helpers shared by
//                the host command decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_cmd_decoder_pkg;

    localparam logic [1:0] OP_SET_ADDR = 2'b00;
    localparam logic [1:0] OP_WRITE    = 2'b01;
    localparam logic [1:0] OP_READ     = 2'b10;
    localparam logic [1:0] OP_RSVD     = 2'b11;

    localparam logic [2:0] ST_CMD   = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;

    typedef enum logic [2:0] {
        S_CMD   = ST_CMD,
        S_ADDR  = ST_ADDR,
        S_LATCH = ST_LATCH,
        S_WRITE = ST_WRITE,
        S_READ  = ST_READ
    } state_t;

    function automatic logic [1:0] cmd_op(input logic [7:0] cmd_byte);
        return cmd_byte[7:6];
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid1.sv
`default_nettype none
// ============================================================================
//  Module      : stream_skid1
//  Description : Single-entry holding register with valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_skid1 #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_load;
    logic             w_drain;

    // Accepting only while empty means load and drain never coincide.
    assign w_load  = i_in_valid & ~r_valid;
    assign w_drain = r_valid & i_out_ready;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= i_in_data;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_in_ready  = ~r_valid;
    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/stream_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : stream_cmd_decoder
//  Description : Parses a host byte stream into SET_ADDR / WRITE / READ
//                transactions for the byte-stream-to-APB bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_cmd_decoder
    import stream_cmd_decoder_pkg::*;
#(
    parameter int LEN_BITS = 6
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic [7:0] host_in_data,
    input  logic       host_in_valid,
    output logic       host_in_ready,
    output logic [7:0] host_out_data,
    output logic       host_out_valid,
    input  logic       host_out_ready,
    output logic [7:0] br_in_data,
    output logic       br_in_valid,
    input  logic       br_in_ready,
    input  logic [7:0] br_out_data,
    input  logic       br_out_valid,
    output logic       br_out_ready,
    output logic [7:0] base_address,
    output logic       latch_address,
    output logic       bad_cmd
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LEN_BITS-1:0] r_remaining;
    logic [LEN_BITS-1:0] w_remaining_nxt;
    logic [7:0]          r_addr;
    logic [7:0]          w_addr_nxt;
    logic                r_bad_cmd;
    logic                w_bad_cmd_nxt;

    logic                w_host_in_ready;
    logic                w_br_in_valid;
    logic [7:0]          w_br_in_data;
    logic                w_br_out_ready;
    logic                w_latch;
    logic                w_skid_in_ready;
    logic                w_hold_valid;
    logic [7:0]          w_hold_data;

    stream_skid1 #(
        .WIDTH (8)
    ) u_rd_hold (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .i_in_data   (br_out_data),
        .i_in_valid  (br_out_valid & w_br_out_ready),
        .o_in_ready  (w_skid_in_ready),
        .o_out_data  (w_hold_data),
        .o_out_valid (w_hold_valid),
        .i_out_ready (host_out_ready)
    );

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_state     <= S_CMD;
            r_remaining <= '0;
            r_addr      <= '0;
            r_bad_cmd   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_addr      <= w_addr_nxt;
            r_bad_cmd   <= w_bad_cmd_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_addr_nxt      = r_addr;
        w_bad_cmd_nxt   = r_bad_cmd;
        w_host_in_ready = 1'b0;
        w_br_in_valid   = 1'b0;
        w_br_in_data    = 8'h00;
        w_br_out_ready  = 1'b0;
        w_latch         = 1'b0;
        // Everything handshake-related stays quiet while reset is held.
        if (RESETn) begin
            case (r_state)
                S_CMD: begin
                    w_host_in_ready = 1'b1;
                    if (host_in_valid) begin
                        w_remaining_nxt = host_in_data[LEN_BITS-1:0];
                        case (cmd_op(host_in_data))
                            OP_SET_ADDR: w_state_nxt   = S_ADDR;
                            OP_WRITE:    w_state_nxt   = S_WRITE;
                            OP_READ:     w_state_nxt   = S_READ;
                            default:     w_bad_cmd_nxt = 1'b1;
                        endcase
                    end
                end
                S_ADDR: begin
                    w_host_in_ready = 1'b1;
                    if (host_in_valid) begin
                        w_addr_nxt  = host_in_data;
                        w_state_nxt = S_LATCH;
                    end
                end
                S_LATCH: begin
                    w_latch = 1'b1;
                    if (br_in_ready) begin
                        w_state_nxt = S_CMD;
                    end
                end
                S_WRITE: begin
                    w_br_in_data    = host_in_data;
                    w_br_in_valid   = host_in_valid;
                    w_host_in_ready = br_in_ready;
                    if (host_in_valid && br_in_ready) begin
                        if (r_remaining == '0) begin
                            w_state_nxt = S_CMD;
                        end else begin
                            w_remaining_nxt = r_remaining - LEN_BITS'(1);
                        end
                    end
                end
                S_READ: begin
                    w_br_out_ready = w_skid_in_ready;
                    // The count advances on delivery to the host, not on the bridge read.
                    if (w_hold_valid && host_out_ready) begin
                        if (r_remaining == '0) begin
                            w_state_nxt = S_CMD;
                        end else begin
                            w_remaining_nxt = r_remaining - LEN_BITS'(1);
                        end
                    end
                end
                default: w_state_nxt = S_CMD;
            endcase
        end
    end

    assign host_in_ready  = w_host_in_ready;
    assign br_in_valid    = w_br_in_valid;
    assign br_in_data     = w_br_in_data;
    assign br_out_ready   = w_br_out_ready;
    assign latch_address  = w_latch;
    assign host_out_valid = RESETn & w_hold_valid;
    assign host_out_data  = RESETn ? w_hold_data : 8'h00;
    assign base_address   = RESETn ? r_addr : 8'h00;
    assign bad_cmd        = RESETn & r_bad_cmd;

endmodule
`default_nettype wire
